ram_dc_mmio: RTL and testbench

//  Parametrised data-RAM decoder for the cpu15 datapath. Replaces the fixed 8-word read mux with
//  on-chip word storage, a req/ack access port and memory-mapped I/O. Sits between the CPU

---
 rtl/ram_dc_mmio_if.sv | 27 ++
 rtl/ram_dc_mmio.sv | 76 +++++++
 tb/tb_ram_dc_mmio.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ram_dc_mmio_if.sv
// ram_dc_mmio_if: access port and I/O pins of the cpu15 data-RAM decoder
interface ram_dc_mmio_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] ram_ad_in;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] io65_in;
    logic              io65_valid;
    logic              ack;
    logic [ADDR_W-1:0] ram_ad_out;
    logic [DATA_W-1:0] ram_out;
    logic              addr_err;
    logic [DATA_W-1:0] io64_out;
    logic              io64_stb;
    logic              io65_pend;
    modport master (
        output req, we, ram_ad_in, ram_data_in, io65_in, io65_valid,
        input  ack, ram_ad_out, ram_out, addr_err, io64_out, io64_stb, io65_pend
    );
    modport slave (
        input  req, we, ram_ad_in, ram_data_in, io65_in, io65_valid,
        output ack, ram_ad_out, ram_out, addr_err, io64_out, io64_stb, io65_pend
    );
endinterface

// File: rtl/ram_dc_mmio.sv
// ram_dc_mmio: word RAM plus memory-mapped IO64/IO65 ports behind a 3-cycle req/ack access
module ram_dc_mmio #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 8,
    parameter int                DEPTH       = 8,
    parameter logic [ADDR_W-1:0] IO_IN_ADDR  = 'h41,
    parameter logic [ADDR_W-1:0] IO_OUT_ADDR = 'h40
) (
    input logic                clk_dc,
    input logic                reset_n,
    ram_dc_mmio_if.slave       bus
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            state, state_nxt;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] latch;
    logic              busy, in_ram, is_out, is_in, err;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] rd_data;
    always_ff @(posedge clk_dc)
        state <= !reset_n ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state == IDLE ? (bus.req ? BUSY : IDLE) : state == BUSY ? RESP : IDLE;
        busy      = state == BUSY;
        in_ram    = c_addr < DEPTH_A;
        is_out    = c_addr == IO_OUT_ADDR;
        is_in     = c_addr == IO_IN_ADDR;
        idx       = c_addr[IW-1:0];
        err       = !(in_ram || is_out || (is_in && !c_we));
        rd_data   = in_ram ? (c_we ? c_data : mem[idx]) :
                    is_out ? (c_we ? c_data : bus.io64_out) :
                    (is_in && !c_we) ? latch : '0;
    end
    always_ff @(posedge clk_dc) begin
        if (!reset_n) begin
            c_we           <= 1'b0;
            c_addr         <= '0;
            c_data         <= '0;
            mem            <= '{default: '0};
            latch          <= '0;
            bus.io65_pend  <= 1'b0;
            bus.ack        <= 1'b0;
            bus.ram_ad_out <= '0;
            bus.ram_out    <= '0;
            bus.addr_err   <= 1'b0;
            bus.io64_out   <= '0;
            bus.io64_stb   <= 1'b0;
        end else begin
            bus.ack      <= busy;
            bus.addr_err <= busy && err;
            bus.io64_stb <= busy && is_out && c_we;
            if (state == IDLE && bus.req) begin
                c_we   <= bus.we;
                c_addr <= bus.ram_ad_in;
                c_data <= bus.ram_data_in;
            end
            if (busy) begin
                bus.ram_ad_out <= c_addr;
                bus.ram_out    <= rd_data;
                if (in_ram && c_we) mem[idx] <= c_data;
                if (is_out && c_we) bus.io64_out <= c_data;
                if (is_in && !c_we) bus.io65_pend <= 1'b0;
            end
            // a capture on the same edge as an IO65 read wins over the clear
            if (bus.io65_valid) begin
                latch         <= bus.io65_in;
                bus.io65_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_dc_mmio.sv
// tb_ram_dc_mmio: directed self-checking bench for ram_dc_mmio
module tb_ram_dc_mmio;
    logic clk_dc = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] r_out;
    logic [7:0]  r_ad;
    logic        r_err, r_stb;
    ram_dc_mmio_if #(.DATA_W(16), .ADDR_W(8)) bus ();
    ram_dc_mmio dut (.clk_dc(clk_dc), .reset_n(reset_n), .bus(bus));
    always #5 clk_dc = ~clk_dc;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // one access; optional IO65 strobe on the execute edge; results left in r_*
    task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d,
                          input logic v = 1'b0, input logic [15:0] vd = '0);
        int n;
        @(negedge clk_dc);
        bus.req = 1'b1; bus.we = w; bus.ram_ad_in = a; bus.ram_data_in = d;
        @(negedge clk_dc);
        bus.req = 1'b0;
        check("ack_early", bus.ack, 1'b0);
        if (v) begin bus.io65_valid = 1'b1; bus.io65_in = vd; end
        n = 0;
        while (!bus.ack && n < 4) begin @(negedge clk_dc); n++; end
        bus.io65_valid = 1'b0;
        check("ack_latency", n, 1);
        r_out = bus.ram_out; r_ad = bus.ram_ad_out; r_err = bus.addr_err; r_stb = bus.io64_stb;
        @(negedge clk_dc);
        check("ack_pulse", {bus.ack, bus.io64_stb, bus.addr_err}, 3'b000);
    endtask
    task automatic pulse_valid(input logic [15:0] vd);
        @(negedge clk_dc);
        bus.io65_valid = 1'b1; bus.io65_in = vd;
        @(negedge clk_dc);
        bus.io65_valid = 1'b0;
    endtask
    initial begin
        logic [7:0]  wa [3] = '{8'd0, 8'd3, 8'd7};
        logic [15:0] wd [3] = '{16'h6535, 16'habcd, 16'h808d};
        bus.req = 0; bus.we = 0; bus.ram_ad_in = 0; bus.ram_data_in = 0;
        bus.io65_in = 0; bus.io65_valid = 0;
        repeat (3) @(negedge clk_dc);
        check("rst_outs", {bus.ack, bus.addr_err, bus.io64_stb, bus.io65_pend, bus.ram_out,
                           bus.ram_ad_out, bus.io64_out}, '0);
        reset_n = 1'b1;
        // 1: cleared RAM
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 8'(i), 16'hffff);
            check("t1_data", r_out, 16'h0000);
            check("t1_err", r_err, 1'b0);
            check("t1_ad", r_ad, 8'(i));
        end
        // 2: writes with echo, then read back
        for (int i = 0; i < 3; i++) begin
            access(1'b1, wa[i], wd[i]);
            check("t2_echo", r_out, wd[i]);
            check("t2_werr", r_err, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            access(1'b0, wa[i], 16'h0);
            check("t2_read", r_out, wd[i]);
        end
        access(1'b0, 8'd1, 16'h0);
        check("t2_addr1", r_out, 16'h0000);
        // 3: IO65 latch and pending flag
        pulse_valid(16'h324f);
        check("t3_pend_set", bus.io65_pend, 1'b1);
        access(1'b0, 8'h41, 16'h0);
        check("t3_read", r_out, 16'h324f);
        check("t3_pend_clr", bus.io65_pend, 1'b0);
        pulse_valid(16'h324f);
        access(1'b0, 8'h41, 16'h0, 1'b1, 16'h1111);
        check("t3_old_val", r_out, 16'h324f);
        check("t3_pend_wins", bus.io65_pend, 1'b1);
        access(1'b0, 8'h41, 16'h0);
        check("t3_new_val", r_out, 16'h1111);
        check("t3_pend_clr2", bus.io65_pend, 1'b0);
        // 4: IO64 output port
        access(1'b1, 8'h40, 16'h34b1);
        check("t4_stb", r_stb, 1'b1);
        check("t4_port", bus.io64_out, 16'h34b1);
        check("t4_echo", r_out, 16'h34b1);
        access(1'b0, 8'h40, 16'h0);
        check("t4_read", r_out, 16'h34b1);
        check("t4_rd_stb", r_stb, 1'b0);
        // 5: unmapped and illegal accesses
        access(1'b0, 8'h20, 16'h0);
        check("t5_err_rd", r_err, 1'b1);
        check("t5_data_rd", r_out, 16'h0000);
        check("t5_ad_rd", r_ad, 8'h20);
        access(1'b1, 8'h41, 16'hdead);
        check("t5_err_wr", r_err, 1'b1);
        check("t5_data_wr", r_out, 16'h0000);
        check("t5_pend", bus.io65_pend, 1'b0);
        access(1'b1, 8'h08, 16'hbeef);
        check("t5_err_oob", r_err, 1'b1);
        access(1'b0, 8'h00, 16'h0);
        check("t5_no_alias", r_out, 16'h6535);
        access(1'b0, 8'h41, 16'h0);
        check("t5_latch", r_out, 16'h1111);
        access(1'b0, 8'd3, 16'h0);
        check("t5_ram", r_out, 16'habcd);
        // 6: reset during the execute cycle of a write
        access(1'b1, 8'd2, 16'h5a5a);
        check("t6_pre", r_out, 16'h5a5a);
        pulse_valid(16'h7777);
        @(negedge clk_dc);
        bus.req = 1'b1; bus.we = 1'b1; bus.ram_ad_in = 8'd2; bus.ram_data_in = 16'h1234;
        @(negedge clk_dc);
        bus.req = 1'b0;
        reset_n = 1'b0;
        @(negedge clk_dc);
        reset_n = 1'b1;
        check("t6_no_ack", bus.ack, 1'b0);
        check("t6_outs", {bus.addr_err, bus.io64_stb, bus.io65_pend, bus.ram_out,
                          bus.ram_ad_out, bus.io64_out}, '0);
        @(negedge clk_dc);
        check("t6_no_ack2", bus.ack, 1'b0);
        access(1'b0, 8'd2, 16'h0);
        check("t6_mem2", r_out, 16'h0000);
        check("t6_ad", r_ad, 8'd2);
        access(1'b0, 8'd3, 16'h0);
        check("t6_mem3", r_out, 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
